// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg: shared definitions for the multicycle RV32I control path.
//   - FSM state encodings (4 bits)
//   - supported opcode constants
//   - alu_op codes (also consumed by the ALU decoder)
//   - alu_src_a / alu_src_b / result_src select codes
//   - ctrl_t: bundle of per-state control values
//   - opcode_supported(): helper that recognises the implemented opcodes
// ---------------------------------------------------------------------------
package ctrl_pkg;

  // FSM state encodings
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // alu_op codes
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Per-state control values before any input-dependent gating
  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       retire;
  } ctrl_t;

  // True for every opcode the FSM knows how to sequence
  function automatic logic opcode_supported(input logic [6:0] op);
    logic ok;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I_ALU, OP_JAL, OP_BRANCH: ok = 1'b1;
      default:                                         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if: bundle between the control FSM and the datapath.
//   Datapath -> control: opcode, funct3, zero, mem_ready
//   Control -> datapath: alu_op, alu_src_a, alu_src_b, result_src, adr_src,
//                        ir_write, pc_write, reg_write, mem_write,
//                        illegal_instr, retire, state_o
//   modport master: datapath side;  modport slave: controller side.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       illegal_instr;
  logic       retire;
  logic [3:0] state_o;

  modport master (
    output opcode, funct3, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, result_src, adr_src,
    input  ir_write, pc_write, reg_write, mem_write,
    input  illegal_instr, retire, state_o
  );

  modport slave (
    input  opcode, funct3, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, result_src, adr_src,
    output ir_write, pc_write, reg_write, mem_write,
    output illegal_instr, retire, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_outputs.sv
// ---------------------------------------------------------------------------
// mc_ctrl_outputs: pure combinational state -> control decoder.
//   state_i : current FSM state
//   ctrl_o  : per-state control values. ir_write/pc_write in FETCH, pc_write
//             in BEQ and retire in MEMWRITE are the ungated values; the top
//             qualifies them with mem_ready / branch outcome.
// ---------------------------------------------------------------------------
module mc_ctrl_outputs
  import ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  output ctrl_t      ctrl_o
);

  // Decode control values from state; unlisted signals stay 0
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.adr_src    = 1'b0;
        ctrl_o.alu_src_a  = SRC_A_PC;
        ctrl_o.alu_src_b  = SRC_B_FOUR;
        ctrl_o.alu_op     = ALU_OP_ADD;
        ctrl_o.result_src = RES_ALU;
        ctrl_o.ir_write   = 1'b1;
        ctrl_o.pc_write   = 1'b1;
      end
      S_DECODE: begin
        // Branch target computed early and parked in ALUOut
        ctrl_o.alu_src_a = SRC_A_OLDPC;
        ctrl_o.alu_src_b = SRC_B_IMM;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = SRC_A_RS1;
        ctrl_o.alu_src_b = SRC_B_IMM;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      S_MEMREAD: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl_o.result_src = RES_RDATA;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      S_EXECR: begin
        ctrl_o.alu_src_a = SRC_A_RS1;
        ctrl_o.alu_src_b = SRC_B_RS2;
        ctrl_o.alu_op    = ALU_OP_FUNCT;
      end
      S_EXECI: begin
        ctrl_o.alu_src_a = SRC_A_RS1;
        ctrl_o.alu_src_b = SRC_B_IMM;
        ctrl_o.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      S_JAL: begin
        // PC <- branch target from ALUOut while ALU forms OldPC+4 for rd
        ctrl_o.alu_src_a  = SRC_A_OLDPC;
        ctrl_o.alu_src_b  = SRC_B_FOUR;
        ctrl_o.alu_op     = ALU_OP_ADD;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.pc_write   = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alu_src_a  = SRC_A_RS1;
        ctrl_o.alu_src_b  = SRC_B_RS2;
        ctrl_o.alu_op     = ALU_OP_SUB;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl: main control FSM of the multicycle RV32I core.
//   clk   : core clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : multicycle_ctrl_if.slave (opcode/funct3/zero/mem_ready in,
//           ALU/mux selects, write enables, illegal_instr, retire,
//           state_o out)
// Parameter ENABLE_BNE: 1 -> branch taken = zero ^ funct3[0] (beq/bne),
//                       0 -> branch taken = zero (funct3 ignored).
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_ctrl_if.slave       bus
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] dec_state_s;
  ctrl_t      raw_s;
  logic       taken_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic       retire_s;
  logic       illegal_s;
  logic       unused_funct3_s;

  // During reset the decoder sees FETCH so selects take their FETCH values
  assign dec_state_s = rst_n ? state_q : S_FETCH;

  assign taken_s         = bus.zero ^ (ENABLE_BNE & bus.funct3[0]);
  assign unused_funct3_s = ^bus.funct3[2:1];

  mc_ctrl_outputs u_dec (
    .state_i (dec_state_s),
    .ctrl_o  (raw_s)
  );

  // Qualify state-decoded enables with mem_ready / branch outcome, kill in reset
  always_comb begin
    ir_write_s = raw_s.ir_write;
    pc_write_s = raw_s.pc_write;
    retire_s   = raw_s.retire;
    illegal_s  = 1'b0;
    case (dec_state_s)
      S_FETCH: begin
        ir_write_s = raw_s.ir_write & bus.mem_ready;
        pc_write_s = raw_s.pc_write & bus.mem_ready;
      end
      S_MEMWRITE: retire_s   = raw_s.retire & bus.mem_ready;
      S_BEQ:      pc_write_s = raw_s.pc_write & taken_s;
      S_DECODE:   illegal_s  = ~opcode_supported(bus.opcode);
      default: begin
        ir_write_s = raw_s.ir_write;
        pc_write_s = raw_s.pc_write;
        retire_s   = raw_s.retire;
        illegal_s  = 1'b0;
      end
    endcase
    if (!rst_n) begin
      ir_write_s = 1'b0;
      pc_write_s = 1'b0;
      retire_s   = 1'b0;
      illegal_s  = 1'b0;
    end else begin
      illegal_s = illegal_s;
    end
  end

  // Next-state logic; unreachable encodings recover to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I_ALU:     state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BRANCH:    state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      // opcode[5] separates SW (1) from LW (0)
      S_MEMADR:   state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.alu_op        = raw_s.alu_op;
  assign bus.alu_src_a     = raw_s.alu_src_a;
  assign bus.alu_src_b     = raw_s.alu_src_b;
  assign bus.result_src    = raw_s.result_src;
  assign bus.adr_src       = raw_s.adr_src;
  assign bus.ir_write      = ir_write_s;
  assign bus.pc_write      = pc_write_s;
  assign bus.reg_write     = rst_n & raw_s.reg_write;
  assign bus.mem_write     = rst_n & raw_s.mem_write;
  assign bus.illegal_instr = illegal_s;
  assign bus.retire        = retire_s;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl. Two DUTs run in
// lockstep (ENABLE_BNE=1 and ENABLE_BNE=0). Each scenario queues per-cycle
// stimulus together with the expected output vector of each DUT; the
// scenario then drives, samples on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] op;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       mw;
    logic       ill;
    logic       ret;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       z;
    logic       rdy;
  } stim_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  stim_t stim_q[$];
  exp_t  sb_q[$];
  exp_t  sb_alt_q[$];

  multicycle_ctrl_if bus0();
  multicycle_ctrl_if bus1();

  multicycle_ctrl #(.ENABLE_BNE(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  multicycle_ctrl #(.ENABLE_BNE(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t ex(input logic [3:0] st, input logic [1:0] op, input logic [1:0] a,
                              input logic [1:0] b, input logic [1:0] rs, input logic adr,
                              input logic irw, input logic pcw, input logic rw, input logic mw,
                              input logic ill, input logic ret);
    exp_t e;
    e = '{st, op, a, b, rs, adr, irw, pcw, rw, mw, ill, ret};
    return e;
  endfunction

  // Expected vectors per state, written out from the control table
  function automatic exp_t e_fetch(input logic rdy);
    return ex(4'd0, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0, rdy, rdy, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t e_decode(input logic ill);
    return ex(4'd1, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ill, 1'b0);
  endfunction
  function automatic exp_t e_memadr();
    return ex(4'd2, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t e_memread();
    return ex(4'd3, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t e_memwb();
    return ex(4'd4, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic exp_t e_memwrite(input logic rdy);
    return ex(4'd5, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
  endfunction
  function automatic exp_t e_execr();
    return ex(4'd6, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t e_execi();
    return ex(4'd7, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t e_aluwb();
    return ex(4'd8, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic exp_t e_jal();
    return ex(4'd9, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t e_beq(input logic taken);
    return ex(4'd10, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, taken, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction
  // Reset held: FETCH selects, all enables low, state shows the register
  function automatic exp_t e_rst(input logic [3:0] st);
    return ex(st, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic stim_t sti(input logic rst, input logic [6:0] opc, input logic [2:0] f3,
                                input logic z, input logic rdy);
    stim_t s;
    s = '{rst, opc, f3, z, rdy};
    return s;
  endfunction

  function automatic exp_t obs0();
    return '{bus0.state_o, bus0.alu_op, bus0.alu_src_a, bus0.alu_src_b, bus0.result_src,
             bus0.adr_src, bus0.ir_write, bus0.pc_write, bus0.reg_write, bus0.mem_write,
             bus0.illegal_instr, bus0.retire};
  endfunction

  function automatic exp_t obs1();
    return '{bus1.state_o, bus1.alu_op, bus1.alu_src_a, bus1.alu_src_b, bus1.result_src,
             bus1.adr_src, bus1.ir_write, bus1.pc_write, bus1.reg_write, bus1.mem_write,
             bus1.illegal_instr, bus1.retire};
  endfunction

  task automatic push(input stim_t s, input exp_t em, input exp_t ea);
    stim_q.push_back(s);
    sb_q.push_back(em);
    sb_alt_q.push_back(ea);
  endtask

  task automatic drive(input stim_t s);
    rst_n          = s.rst;
    bus0.opcode    = s.opc;  bus1.opcode    = s.opc;
    bus0.funct3    = s.f3;   bus1.funct3    = s.f3;
    bus0.zero      = s.z;    bus1.zero      = s.z;
    bus0.mem_ready = s.rdy;  bus1.mem_ready = s.rdy;
  endtask

  task automatic test_reset();
    stim_t s;
    exp_t em, ea, om, oa;
    int cyc = 0;
    drive(sti(1'b0, OP_R, 3'd0, 1'b0, 1'b1));
    @(posedge clk); #1;
    // mem_ready high while in reset: ir/pc write must still be suppressed
    push(sti(1'b0, OP_R, 3'd0, 1'b0, 1'b1), e_rst(S_FETCH), e_rst(S_FETCH));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      em = sb_q.pop_front(); ea = sb_alt_q.pop_front(); om = obs0(); oa = obs1();
      n_checks += 2;
      if (om !== em) begin n_fail++; $display("FAIL reset cyc%0d bne1: got %h expected %h", cyc, om, em); end
      if (oa !== ea) begin n_fail++; $display("FAIL reset cyc%0d bne0: got %h expected %h", cyc, oa, ea); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_r_type();
    stim_t s;
    exp_t em, ea, om, oa;
    int cyc = 0;
    push(sti(1'b1, OP_R, 3'd0, 1'b0, 1'b1), e_fetch(1'b1), e_fetch(1'b1));
    push(sti(1'b1, OP_R, 3'd0, 1'b0, 1'b1), e_decode(1'b0), e_decode(1'b0));
    push(sti(1'b1, OP_R, 3'd0, 1'b0, 1'b1), e_execr(), e_execr());
    push(sti(1'b1, OP_R, 3'd0, 1'b0, 1'b1), e_aluwb(), e_aluwb());
    // I-ALU follows: first cycle also confirms the return to FETCH
    push(sti(1'b1, OP_I_ALU, 3'd0, 1'b0, 1'b1), e_fetch(1'b1), e_fetch(1'b1));
    push(sti(1'b1, OP_I_ALU, 3'd0, 1'b0, 1'b1), e_decode(1'b0), e_decode(1'b0));
    push(sti(1'b1, OP_I_ALU, 3'd0, 1'b0, 1'b1), e_execi(), e_execi());
    push(sti(1'b1, OP_I_ALU, 3'd0, 1'b0, 1'b1), e_aluwb(), e_aluwb());
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      em = sb_q.pop_front(); ea = sb_alt_q.pop_front(); om = obs0(); oa = obs1();
      n_checks += 2;
      if (om !== em) begin n_fail++; $display("FAIL alu_ops cyc%0d bne1: got %h expected %h", cyc, om, em); end
      if (oa !== ea) begin n_fail++; $display("FAIL alu_ops cyc%0d bne0: got %h expected %h", cyc, oa, ea); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    stim_t s;
    exp_t em, ea, om, oa;
    int cyc = 0;
    push(sti(1'b1, OP_LW, 3'd2, 1'b0, 1'b0), e_fetch(1'b0), e_fetch(1'b0));
    push(sti(1'b1, OP_LW, 3'd2, 1'b0, 1'b0), e_fetch(1'b0), e_fetch(1'b0));
    push(sti(1'b1, OP_LW, 3'd2, 1'b0, 1'b1), e_fetch(1'b1), e_fetch(1'b1));
    // mem_ready low in DECODE/MEMADR must not stall
    push(sti(1'b1, OP_LW, 3'd2, 1'b0, 1'b0), e_decode(1'b0), e_decode(1'b0));
    push(sti(1'b1, OP_LW, 3'd2, 1'b0, 1'b0), e_memadr(), e_memadr());
    push(sti(1'b1, OP_LW, 3'd2, 1'b0, 1'b0), e_memread(), e_memread());
    push(sti(1'b1, OP_LW, 3'd2, 1'b0, 1'b0), e_memread(), e_memread());
    push(sti(1'b1, OP_LW, 3'd2, 1'b0, 1'b0), e_memread(), e_memread());
    push(sti(1'b1, OP_LW, 3'd2, 1'b0, 1'b1), e_memread(), e_memread());
    push(sti(1'b1, OP_LW, 3'd2, 1'b0, 1'b0), e_memwb(), e_memwb());
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      em = sb_q.pop_front(); ea = sb_alt_q.pop_front(); om = obs0(); oa = obs1();
      n_checks += 2;
      if (om !== em) begin n_fail++; $display("FAIL lw cyc%0d bne1: got %h expected %h", cyc, om, em); end
      if (oa !== ea) begin n_fail++; $display("FAIL lw cyc%0d bne0: got %h expected %h", cyc, oa, ea); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_stall();
    stim_t s;
    exp_t em, ea, om, oa;
    int cyc = 0;
    push(sti(1'b1, OP_SW, 3'd2, 1'b0, 1'b1), e_fetch(1'b1), e_fetch(1'b1));
    push(sti(1'b1, OP_SW, 3'd2, 1'b0, 1'b1), e_decode(1'b0), e_decode(1'b0));
    push(sti(1'b1, OP_SW, 3'd2, 1'b0, 1'b1), e_memadr(), e_memadr());
    push(sti(1'b1, OP_SW, 3'd2, 1'b0, 1'b0), e_memwrite(1'b0), e_memwrite(1'b0));
    push(sti(1'b1, OP_SW, 3'd2, 1'b0, 1'b1), e_memwrite(1'b1), e_memwrite(1'b1));
    push(sti(1'b1, OP_SW, 3'd2, 1'b0, 1'b0), e_fetch(1'b0), e_fetch(1'b0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      em = sb_q.pop_front(); ea = sb_alt_q.pop_front(); om = obs0(); oa = obs1();
      n_checks += 2;
      if (om !== em) begin n_fail++; $display("FAIL sw cyc%0d bne1: got %h expected %h", cyc, om, em); end
      if (oa !== ea) begin n_fail++; $display("FAIL sw cyc%0d bne0: got %h expected %h", cyc, oa, ea); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    stim_t s;
    exp_t em, ea, om, oa;
    int cyc = 0;
    logic [2:0] f3_tab[4];
    logic       z_tab[4];
    logic       tk_bne1[4];
    logic       tk_bne0[4];
    f3_tab  = '{3'b000, 3'b000, 3'b001, 3'b001};
    z_tab   = '{1'b1,   1'b0,   1'b1,   1'b0};
    tk_bne1 = '{1'b1,   1'b0,   1'b0,   1'b1};
    tk_bne0 = '{1'b1,   1'b0,   1'b1,   1'b0};
    for (int i = 0; i < 4; i++) begin
      push(sti(1'b1, OP_BRANCH, f3_tab[i], z_tab[i], 1'b1), e_fetch(1'b1), e_fetch(1'b1));
      push(sti(1'b1, OP_BRANCH, f3_tab[i], z_tab[i], 1'b1), e_decode(1'b0), e_decode(1'b0));
      push(sti(1'b1, OP_BRANCH, f3_tab[i], z_tab[i], 1'b1), e_beq(tk_bne1[i]), e_beq(tk_bne0[i]));
    end
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      em = sb_q.pop_front(); ea = sb_alt_q.pop_front(); om = obs0(); oa = obs1();
      n_checks += 2;
      if (om !== em) begin n_fail++; $display("FAIL branch cyc%0d bne1: got %h expected %h", cyc, om, em); end
      if (oa !== ea) begin n_fail++; $display("FAIL branch cyc%0d bne0: got %h expected %h", cyc, oa, ea); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jal();
    stim_t s;
    exp_t em, ea, om, oa;
    int cyc = 0;
    push(sti(1'b1, OP_JAL, 3'd0, 1'b0, 1'b1), e_fetch(1'b1), e_fetch(1'b1));
    push(sti(1'b1, OP_JAL, 3'd0, 1'b0, 1'b1), e_decode(1'b0), e_decode(1'b0));
    push(sti(1'b1, OP_JAL, 3'd0, 1'b0, 1'b1), e_jal(), e_jal());
    push(sti(1'b1, OP_JAL, 3'd0, 1'b0, 1'b1), e_aluwb(), e_aluwb());
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      em = sb_q.pop_front(); ea = sb_alt_q.pop_front(); om = obs0(); oa = obs1();
      n_checks += 2;
      if (om !== em) begin n_fail++; $display("FAIL jal cyc%0d bne1: got %h expected %h", cyc, om, em); end
      if (oa !== ea) begin n_fail++; $display("FAIL jal cyc%0d bne0: got %h expected %h", cyc, oa, ea); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    stim_t s;
    exp_t em, ea, om, oa;
    int cyc = 0;
    logic [6:0] bad;
    bad = 7'b1110011;
    push(sti(1'b1, bad, 3'd0, 1'b0, 1'b1), e_fetch(1'b1), e_fetch(1'b1));
    push(sti(1'b1, bad, 3'd0, 1'b0, 1'b1), e_decode(1'b1), e_decode(1'b1));
    push(sti(1'b1, OP_R, 3'd0, 1'b0, 1'b0), e_fetch(1'b0), e_fetch(1'b0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      em = sb_q.pop_front(); ea = sb_alt_q.pop_front(); om = obs0(); oa = obs1();
      n_checks += 2;
      if (om !== em) begin n_fail++; $display("FAIL illegal cyc%0d bne1: got %h expected %h", cyc, om, em); end
      if (oa !== ea) begin n_fail++; $display("FAIL illegal cyc%0d bne0: got %h expected %h", cyc, oa, ea); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midwrite();
    stim_t s;
    exp_t em, ea, om, oa;
    int cyc = 0;
    push(sti(1'b1, OP_SW, 3'd2, 1'b0, 1'b1), e_fetch(1'b1), e_fetch(1'b1));
    push(sti(1'b1, OP_SW, 3'd2, 1'b0, 1'b1), e_decode(1'b0), e_decode(1'b0));
    push(sti(1'b1, OP_SW, 3'd2, 1'b0, 1'b1), e_memadr(), e_memadr());
    push(sti(1'b1, OP_SW, 3'd2, 1'b0, 1'b0), e_memwrite(1'b0), e_memwrite(1'b0));
    // rst_n drops: enables die at once, state register still MEMWRITE
    push(sti(1'b0, OP_SW, 3'd2, 1'b0, 1'b1), e_rst(S_MEMWRITE), e_rst(S_MEMWRITE));
    push(sti(1'b0, OP_SW, 3'd2, 1'b0, 1'b1), e_rst(S_FETCH), e_rst(S_FETCH));
    push(sti(1'b1, OP_SW, 3'd2, 1'b0, 1'b1), e_fetch(1'b1), e_fetch(1'b1));
    push(sti(1'b1, OP_SW, 3'd2, 1'b0, 1'b1), e_decode(1'b0), e_decode(1'b0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      em = sb_q.pop_front(); ea = sb_alt_q.pop_front(); om = obs0(); oa = obs1();
      n_checks += 2;
      if (om !== em) begin n_fail++; $display("FAIL rst_midwrite cyc%0d bne1: got %h expected %h", cyc, om, em); end
      if (oa !== ea) begin n_fail++; $display("FAIL rst_midwrite cyc%0d bne0: got %h expected %h", cyc, oa, ea); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_r_type();
    test_lw_stall();
    test_sw_stall();
    test_branch();
    test_jal();
    test_illegal();
    test_reset_midwrite();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core. Sequences one shared ALU, the unified instruction/data memory port, the IR, the PC and the register-file write port.
- Produces the 2-bit alu_op consumed by the ALU decoder, plus every mux select and write enable.
- Stalls on memory via a ready handshake. Flags unsupported opcodes.

Parameters:
- ENABLE_BNE, 1, when 1 branch outcome is zero XOR funct3[0] (beq/bne); when 0 only beq is taken-on-zero and funct3 is ignored.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset
- opcode  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- alu_op  out  2  00 add, 01 sub (branch compare), 10 use funct3/funct7
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 data
- alu_src_b  out  2  00 rs2 data, 01 immediate, 10 constant 4
- result_src  out  2  00 ALUOut reg, 01 read data, 10 ALU result
- adr_src  out  1  0 PC, 1 result bus
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  load PC from result bus
- reg_write  out  1  write rd
- mem_write  out  1  store request
- illegal_instr  out  1  one-cycle pulse, unsupported opcode
- retire  out  1  one-cycle pulse, final cycle of each completed instruction
- state_o  out  4  current state, debug only

Behaviour:
- State register updates on rising clk. rst_n low at an edge forces FETCH.
- While rst_n is low, ir_write, pc_write, reg_write, mem_write, illegal_instr and retire are forced to 0 combinationally. All other outputs take their FETCH values.
- Reset mid-instruction abandons it with no write enables asserted.
- Outputs are decoded from state only, except the FETCH/MEMWRITE gating on mem_ready and the BEQ gating on taken. Any signal not listed for a state is 0.
- Opcodes: LW 0000011, SW 0100011, R 0110011, I-ALU 0010011, JAL 1101111, BRANCH 1100011.
- FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write=pc_write=mem_ready. If mem_ready go to DECODE, else stay.
- DECODE: a=01, b=01, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - LW or SW -> MEMADR
  - R -> EXECR
  - I-ALU -> EXECI
  - JAL -> JAL
  - BRANCH -> BEQ
  - anything else -> FETCH, with illegal_instr=1 and no retire.
- MEMADR: a=10, b=01, alu_op=00. Go to MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Stay until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, retire=1. Go to FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1, held every cycle until mem_ready. retire=mem_ready. Go to FETCH on mem_ready.
- EXECR: a=10, b=00, alu_op=10. Go to ALUWB.
- EXECI: a=10, b=01, alu_op=10. Go to ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1. Go to FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1. Go to ALUWB (rd=OldPC+4).
- BEQ: a=10, b=00, alu_op=01, result_src=00, retire=1. pc_write=taken, where taken = zero ^ (ENABLE_BNE & funct3[0]). Go to FETCH.
- Cycle counts with mem_ready always 1:
  - LW 5 cycles
  - SW 4 cycles
  - R/I-ALU 4 cycles
  - JAL 4 cycles
  - branch 3 cycles
  - illegal 2 cycles
- Each cycle mem_ready is low in FETCH/MEMREAD/MEMWRITE adds one cycle.
- mem_ready outside these states is ignored.
- Unreachable state encodings go to FETCH with all enables 0.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum (4 bits: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ)
  - opcode constants
  - alu_op codes
  - alu_src_a, alu_src_b and result_src select codes
- The ALU decoder reuses the alu_op codes from this package.
- One sub-module is natural: mc_ctrl_outputs, a pure combinational state-to-controls decoder. The top keeps the state register, next-state logic and gating.

Test Plan:
- Reset, then R-type add (opcode 0110011), mem_ready=1 -> state sequence FETCH, DECODE, EXECR, ALUWB, FETCH. alu_op=10 in EXECR. reg_write and retire asserted only in cycle 4.
- LW with mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> ir_write/pc_write high only on the FETCH ready cycle. Total 10 cycles. reg_write with result_src=01 once.
- SW with mem_ready low 1 cycle -> mem_write high both MEMWRITE cycles, adr_src=1, retire only on the ready cycle. No reg_write.
- Branch: beq with zero=1 -> pc_write=1 in BEQ. bne (funct3=001) with zero=1, ENABLE_BNE=1 -> pc_write=0. Same bne with ENABLE_BNE=0 -> pc_write=1. Sequence is 3 cycles, alu_op=01.
- JAL -> pc_write in JAL with a=01, b=10. Then ALUWB reg_write. 4 cycles, one retire.
- Opcode 1110011 -> illegal_instr pulse in DECODE, back to FETCH, no write enables. Separately, rst_n low during MEMWRITE -> mem_write=0 immediately and state_o=FETCH after the edge.
